reg_dst_scoreboard: RTL
=======================

Name: reg_dst_scoreboard

Overview:
- Read-side counterpart to the destination-register select path in the pipeline.
- The write-register select (rt / rd / $31) produces a 5-bit destination at issue. This block records that destination as pending until writeback releases it.
- Decode-stage source reads (rs/rt) check it and receive a stall when they would read a register still in flight.
- Sits between ID (check/issue) and WB (release).

Parameters:
MAX_PENDING, 3, maximum in-flight writes tracked per register (1..7)
CW, 2, pending-counter width; must hold MAX_PENDING
STALL_W, 16, width of the saturating stall-cycle counter

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high; clears all state
issue_valid  input  1  ID presents an instruction that writes a register
issue_dst  input  5  destination register from the dst-select mux
issue_ready  output  1  issue accepted this cycle when issue_valid && issue_ready
use_rs  input  1  instruction in ID reads rs
rs  input  5  source register rs
use_rt  input  1  instruction in ID reads rt
rt  input  5  source register rt
wb_valid  input  1  WB stage retires a register write
wb_dst  input  5  register being written back
stall  output  1  combinational RAW stall request to ID/IF
busy_regs  output  6  number of registers with nonzero pending count (0..31)
err_underflow  output  1  sticky: wb to a register with count 0
err_overflow  output  1  sticky: issue_valid to a register already at MAX_PENDING while otherwise ready
stall_cycles  output  STALL_W  saturating count of cycles with stall=1

Behaviour:
- State: cnt[1..31], CW bits each. Register 0 has no counter and is never pending.
- Issues and writebacks with dst=0 are ignored: no counter change, no error.
- pending(r) = (r != 0) && cnt[r] != 0.
- stall = (use_rs && pending(rs)) || (use_rt && pending(rt)). Purely combinational from current state; no same-cycle bypass unless the optional feature is enabled.
- issue_ready = !stall && !(issue_dst != 0 && cnt[issue_dst] == MAX_PENDING).
- Accept = issue_valid && issue_ready. When accepted: cnt[issue_dst] +1 next edge.
- Release = wb_valid && wb_dst != 0:
  - If cnt[wb_dst] > 0: cnt[wb_dst] -1 next edge.
  - If cnt[wb_dst] == 0: count stays 0 and err_underflow is set.
- Accept and release to the same register in the same cycle: count unchanged, no error, even if count is 0 or MAX_PENDING.
- Accept and release to different registers in the same cycle: both applied.
- err_overflow sets when issue_valid && !stall && issue_dst != 0 && cnt[issue_dst] == MAX_PENDING. The issue is not accepted.
- err_underflow and err_overflow hold until Reset.
- busy_regs is registered. It reflects the counts after the current edge, so it updates one cycle after the causing event.
- stall_cycles increments on every edge where stall=1 and saturates at all-ones.
- Reset (synchronous) applies even mid-operation:
  - All cnt = 0, busy_regs = 0, errors = 0, stall_cycles = 0.
  - Issue and wb in the reset cycle are discarded.
  - Post-reset outputs: stall=0; issue_ready=1 for any issue_dst.
- Latency: issue to visible pending = 1 cycle. wb to clear = 1 cycle (0 with the optional feature).

Optional Feature:
- Macro SCOREBOARD_WB_BYPASS_EN.
- Defined: a register whose cnt == 1 and that is being released this cycle (wb_valid, wb_dst match) is treated as not pending for stall and issue_ready evaluation in that same cycle. Models the write-first-half / read-second-half register file.
- Undefined: no bypass; the read stalls one extra cycle after the final writeback.

Test Plan:
- Reset, then issue_valid dst=5 -> next cycle busy_regs=1. With use_rs=1, rs=5: stall=1, issue_ready=0. Then wb_dst=5 -> next cycle stall=0, busy_regs=0.
- Issue dst=0, use_rt=1, rt=0 -> stall=0 always, busy_regs stays 0, no errors.
- Three issues to dst=9 (MAX_PENDING=3), then a 4th -> not accepted, err_overflow=1. Three wb to 9 -> cnt 0. A 4th wb -> err_underflow=1.
- Same-cycle issue dst=7 and wb dst=7 with cnt[7]=1 -> cnt[7] stays 1, no error. Different regs (issue 3, wb 7) -> cnt[3]=1, cnt[7]=0.
- Stall held 5 cycles -> stall_cycles=5. Assert Reset mid-stall -> next cycle all counts 0, stall_cycles=0, errors 0.
- With SCOREBOARD_WB_BYPASS_EN: cnt[12]=1, use_rs=1 rs=12, wb_dst=12 same cycle -> stall=0 that cycle. Without the macro -> stall=1 that cycle and 0 the next.

Source files
------------

// File: rtl/reg_dst_scoreboard.sv
// Per-register pending-write scoreboard: issue marks a destination in flight, writeback releases it.
// Optional SCOREBOARD_WB_BYPASS_EN lets a final same-cycle writeback clear the RAW stall.
module reg_dst_scoreboard #(
  parameter int unsigned MAX_PENDING = 3,
  parameter int unsigned CW          = 2,
  parameter int unsigned STALL_W     = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               issue_valid,
  input  logic [4:0]         issue_dst,
  output logic               issue_ready,
  input  logic               use_rs,
  input  logic [4:0]         rs,
  input  logic               use_rt,
  input  logic [4:0]         rt,
  input  logic               wb_valid,
  input  logic [4:0]         wb_dst,
  output logic               stall,
  output logic [5:0]         busy_regs,
  output logic               err_underflow,
  output logic               err_overflow,
  output logic [STALL_W-1:0] stall_cycles
);

  localparam logic [CW-1:0] MaxCnt = CW'(MAX_PENDING);
  localparam logic [CW-1:0] OneCnt = CW'(1);

  // Entry 0 is held at zero so r0 never reads as pending.
  logic [CW-1:0]      cnt_q [32];
  logic [CW-1:0]      cnt_d [32];
  logic [5:0]         busy_q, busy_d;
  logic               unf_q, unf_d;
  logic               ovf_q, ovf_d;
  logic [STALL_W-1:0] sc_q, sc_d;

  logic rs_pend, rt_pend, dst_full, accept, wb_rel;
  logic inc, hit_wb;

  always_comb begin
    rs_pend = (rs != 5'd0) && (cnt_q[rs] != '0);
    rt_pend = (rt != 5'd0) && (cnt_q[rt] != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    // Register file writes in the first half-cycle, so the last release is readable now.
    if (wb_valid && (wb_dst == rs) && (cnt_q[rs] == OneCnt)) rs_pend = 1'b0;
    if (wb_valid && (wb_dst == rt) && (cnt_q[rt] == OneCnt)) rt_pend = 1'b0;
`endif
    stall       = (use_rs && rs_pend) || (use_rt && rt_pend);
    dst_full    = (issue_dst != 5'd0) && (cnt_q[issue_dst] == MaxCnt);
    issue_ready = !stall && !dst_full;
    accept      = issue_valid && issue_ready;
    wb_rel      = wb_valid && (wb_dst != 5'd0);
  end

  always_comb begin
    cnt_d[0] = '0;
    busy_d   = 6'd0;
    inc      = 1'b0;
    hit_wb   = 1'b0;
    for (int unsigned i = 1; i < 32; i++) begin
      inc    = accept && (issue_dst == i[4:0]);
      hit_wb = wb_rel && (wb_dst == i[4:0]);
      cnt_d[i] = cnt_q[i];
      // Accept and release on the same register cancel out.
      if (inc && !hit_wb) begin
        cnt_d[i] = cnt_q[i] + OneCnt;
      end else if (!inc && hit_wb && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - OneCnt;
      end
      if (cnt_d[i] != '0) busy_d = busy_d + 6'd1;
    end

    ovf_d = ovf_q || (issue_valid && !stall && dst_full);
    unf_d = unf_q || (wb_rel && (cnt_q[wb_dst] == '0) && !(accept && (issue_dst == wb_dst)));
    sc_d  = (stall && (sc_q != '1)) ? sc_q + STALL_W'(1) : sc_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
      busy_q <= 6'd0;
      unf_q  <= 1'b0;
      ovf_q  <= 1'b0;
      sc_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      unf_q  <= unf_d;
      ovf_q  <= ovf_d;
      sc_q   <= sc_d;
    end
  end

  assign busy_regs     = busy_q;
  assign err_underflow = unf_q;
  assign err_overflow  = ovf_q;
  assign stall_cycles  = sc_q;

endmodule
